mm_sequencer: RTL and testbench

MM_SEQUENCER -- requirements
Module: mm_sequencer

---
 rtl/mm_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_mm_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mm_sequencer
// Description : Command-driven sequencer for one matrix-multiply pass on a
//               systolic array. On an accepted command it reads SYS_ROWS
//               weight rows from the buffer (highest row first). It then reads
//               N activation rows (lowest row first) and forwards each row to
//               the array one cycle after the read. It then issues the MATMUL
//               instruction and a start pulse, and waits for the array to
//               report completion before pulsing done.
//
// Ports       : clk, rst        clock, synchronous active-high reset
//               cmd_valid       command offered (accepted only while idle)
//               cmd_ready       high iff the sequencer is idle
//               cmd_w_base      weight-row base address
//               cmd_a_base      activation-row base address
//               cmd_a_rows      activation row count N (1..A_ROWS_MAX legal)
//               mem_rd_en       buffer read strobe
//               mem_addr        buffer read address (0 when not reading)
//               mem_rdata       buffer read data, one cycle after mem_rd_en
//               w_valid, wdata  weight row to array (data zeroed when invalid)
//               if_valid,if_data activation row to array (zeroed when invalid)
//               instr_valid,instr MATMUL instruction to array
//               start           one-cycle start pulse to array
//               acc_ready       array completion level
//               busy, done, err not idle / completion pulse / bad-command pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module mm_sequencer #(
    parameter int                    SYS_ROWS     = 4,
    parameter int                    SYS_COLS     = 4,
    parameter int                    W_BITWIDTH   = 8,
    parameter int                    ADDR_W       = 10,
    parameter int                    A_ROWS_MAX   = 16,
    parameter int                    INSTR_SIZE   = 2,
    parameter logic [INSTR_SIZE-1:0] INSTR_MATMUL = 2'b11,
    parameter int                    MIN_WAIT     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [ADDR_W-1:0]                    cmd_w_base,
    input  logic [ADDR_W-1:0]                    cmd_a_base,
    input  logic [$clog2(A_ROWS_MAX+1)-1:0]      cmd_a_rows,

    output logic                                 mem_rd_en,
    output logic [ADDR_W-1:0]                    mem_addr,
    input  logic [SYS_COLS*W_BITWIDTH-1:0]       mem_rdata,

    output logic [SYS_COLS-1:0]                  w_valid,
    output logic [SYS_COLS*W_BITWIDTH-1:0]       wdata,
    output logic [SYS_COLS-1:0]                  if_valid,
    output logic [SYS_COLS*W_BITWIDTH-1:0]       if_data,

    output logic                                 instr_valid,
    output logic [INSTR_SIZE-1:0]                instr,
    output logic                                 start,
    input  logic                                 acc_ready,

    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_N_W    = $clog2(A_ROWS_MAX + 1);
    localparam int c_S_W    = $clog2(SYS_ROWS + 1);
    // One row counter serves both load phases, so it must hold either count.
    localparam int c_CNT_W  = (c_N_W > c_S_W) ? c_N_W : c_S_W;
    // +2 keeps the width non-zero when MIN_WAIT is 0.
    localparam int c_WAIT_W = $clog2(MIN_WAIT + 2);

    localparam logic [3:0] c_ST_IDLE   = 4'd0;
    localparam logic [3:0] c_ST_LOAD_W = 4'd1;
    localparam logic [3:0] c_ST_GAP_W  = 4'd2;
    localparam logic [3:0] c_ST_LOAD_A = 4'd3;
    localparam logic [3:0] c_ST_GAP_A  = 4'd4;
    localparam logic [3:0] c_ST_DRAIN  = 4'd5;
    localparam logic [3:0] c_ST_INSTR  = 4'd6;
    localparam logic [3:0] c_ST_START  = 4'd7;
    localparam logic [3:0] c_ST_WAIT   = 4'd8;
    localparam logic [3:0] c_ST_DONE   = 4'd9;
    localparam logic [3:0] c_ST_ERR    = 4'd10;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [3:0]          r_state;
    logic [3:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
    logic [ADDR_W-1:0]   r_w_base;
    logic [ADDR_W-1:0]   w_w_base_nxt;
    logic [ADDR_W-1:0]   r_a_base;
    logic [ADDR_W-1:0]   w_a_base_nxt;
    logic [c_N_W-1:0]    r_a_rows;
    logic [c_N_W-1:0]    w_a_rows_nxt;
    logic                r_w_valid;
    logic                r_if_valid;

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------
    logic              w_accept;
    logic              w_rows_bad;
    logic              w_last_w;
    logic              w_last_a;
    logic              w_wait_exit;
    logic              w_in_load_w;
    logic              w_in_load_a;
    logic [ADDR_W-1:0] w_addr_w;
    logic [ADDR_W-1:0] w_addr_a;

    assign w_accept    = cmd_valid && (r_state == c_ST_IDLE);
    assign w_rows_bad  = (cmd_a_rows == '0) ||
                         (cmd_a_rows > c_N_W'(A_ROWS_MAX));
    assign w_in_load_w = (r_state == c_ST_LOAD_W);
    assign w_in_load_a = (r_state == c_ST_LOAD_A);
    assign w_last_w    = (r_cnt == c_CNT_W'(SYS_ROWS - 1));
    assign w_last_a    = (r_cnt == (c_CNT_W'(r_a_rows) - c_CNT_W'(1)));
    // acc_ready only counts once the minimum settle time has elapsed.
    assign w_wait_exit = (r_wait_cnt >= c_WAIT_W'(MIN_WAIT)) && acc_ready;

    // Weights are fetched top row first; address arithmetic wraps naturally.
    assign w_addr_w = r_w_base + ADDR_W'(SYS_ROWS - 1) - ADDR_W'(r_cnt);
    assign w_addr_a = r_a_base + ADDR_W'(r_cnt);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_w_base_nxt   = r_w_base;
        w_a_base_nxt   = r_a_base;
        w_a_rows_nxt   = r_a_rows;

        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    // Fields are captured once; later changes are ignored.
                    w_w_base_nxt = cmd_w_base;
                    w_a_base_nxt = cmd_a_base;
                    w_a_rows_nxt = cmd_a_rows;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = w_rows_bad ? c_ST_ERR : c_ST_LOAD_W;
                end
            end
            c_ST_LOAD_W: begin
                if (w_last_w) begin
                    w_state_nxt = c_ST_GAP_W;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_GAP_W: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_ST_LOAD_A;
            end
            c_ST_LOAD_A: begin
                if (w_last_a) begin
                    w_state_nxt = c_ST_GAP_A;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_GAP_A: w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: w_state_nxt = c_ST_INSTR;
            c_ST_INSTR: w_state_nxt = c_ST_START;
            c_ST_START: begin
                w_wait_cnt_nxt = '0;
                w_state_nxt    = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (w_wait_exit) begin
                    w_state_nxt = c_ST_DONE;
                end else if (r_wait_cnt < c_WAIT_W'(MIN_WAIT)) begin
                    // Saturate: only the ">= MIN_WAIT" fact matters afterwards.
                    w_wait_cnt_nxt = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            c_ST_ERR:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_wait_cnt <= '0;
            r_w_base   <= '0;
            r_a_base   <= '0;
            r_a_rows   <= '0;
            r_w_valid  <= 1'b0;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_w_base   <= w_w_base_nxt;
            r_a_base   <= w_a_base_nxt;
            r_a_rows   <= w_a_rows_nxt;
            // Read data returns one cycle after the strobe, so the valid
            // flags are the strobe delayed by one cycle, split by phase.
            r_w_valid  <= w_in_load_w;
            r_if_valid <= w_in_load_a;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_ready   = (r_state == c_ST_IDLE);
    assign busy        = (r_state != c_ST_IDLE);
    assign done        = (r_state == c_ST_DONE);
    assign err         = (r_state == c_ST_ERR);
    assign start       = (r_state == c_ST_START);
    assign instr_valid = (r_state == c_ST_INSTR);
    assign instr       = instr_valid ? INSTR_MATMUL : '0;

    assign mem_rd_en   = w_in_load_w || w_in_load_a;
    assign mem_addr    = w_in_load_w ? w_addr_w :
                         w_in_load_a ? w_addr_a : '0;

    assign w_valid     = {SYS_COLS{r_w_valid}};
    assign if_valid    = {SYS_COLS{r_if_valid}};
    assign wdata       = r_w_valid  ? mem_rdata : '0;
    assign if_data     = r_if_valid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mm_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mm_sequencer
// Description : Self-checking bench for mm_sequencer. Every cycle's outputs
//               are predicted from the cycle index relative to command
//               acceptance. A table of directed commands is applied, followed
//               by hand-written corner sequences and randomized commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_sequencer;

    localparam int S    = 4;
    localparam int AMAX = 16;
    localparam int MINW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_w_base;
    logic [9:0]  cmd_a_base;
    logic [4:0]  cmd_a_rows;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [3:0]  w_valid;
    logic [31:0] wdata;
    logic [3:0]  if_valid;
    logic [31:0] if_data;
    logic        instr_valid;
    logic [1:0]  instr;
    logic        start;
    logic        acc_ready;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    mm_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_w_base  (cmd_w_base),
        .cmd_a_base  (cmd_a_base),
        .cmd_a_rows  (cmd_a_rows),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .w_valid     (w_valid),
        .wdata       (wdata),
        .if_valid    (if_valid),
        .if_data     (if_data),
        .instr_valid (instr_valid),
        .instr       (instr),
        .start       (start),
        .acc_ready   (acc_ready),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct packed {
        logic        cmd_ready;
        logic        busy;
        logic        done;
        logic        err;
        logic        mem_rd_en;
        logic [9:0]  mem_addr;
        logic [3:0]  w_valid;
        logic [31:0] wdata;
        logic [3:0]  if_valid;
        logic [31:0] if_data;
        logic        instr_valid;
        logic [1:0]  instr;
        logic        start;
    } snap_t;

    typedef struct {
        logic [9:0] wb;
        logic [9:0] ab;
        int         n;
        int         acc_from;
        int         exp_done;   // hand-derived done cycle (unused for bad N)
        int         noise;      // 0 quiet, 1 random cmd traffic, 2 cmd_valid held
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit acc_pat [0:127];

    function automatic snap_t idle_snap();
        snap_t e = '0;
        e.cmd_ready = 1'b1;
        return e;
    endfunction

    // Expected outputs in cycle k after an accept at edge 0, from the timeline:
    // weights read 1..S, activations S+2..S+1+N, instr S+4+N, start S+5+N,
    // done at cycle d.
    function automatic snap_t model(int k, logic [9:0] wb, logic [9:0] ab,
                                    int n, int d, logic [31:0] rd);
        snap_t e = '0;
        if (n == 0 || n > AMAX) begin
            if (k == 1) begin
                e.err  = 1'b1;
                e.busy = 1'b1;
            end else begin
                e.cmd_ready = 1'b1;
            end
            return e;
        end
        e.busy      = (k <= d);
        e.cmd_ready = (k > d);
        e.done      = (k == d);
        if (k >= 1 && k <= S) begin
            e.mem_rd_en = 1'b1;
            e.mem_addr  = wb + 10'(S - k);
        end
        if (k >= S + 2 && k <= S + 1 + n) begin
            e.mem_rd_en = 1'b1;
            e.mem_addr  = ab + 10'(k - S - 2);
        end
        if (k >= 2 && k <= S + 1) begin
            e.w_valid = 4'hF;
            e.wdata   = rd;
        end
        if (k >= S + 3 && k <= S + 2 + n) begin
            e.if_valid = 4'hF;
            e.if_data  = rd;
        end
        if (k == S + 4 + n) begin
            e.instr_valid = 1'b1;
            e.instr       = 2'b11;
        end
        e.start = (k == S + 5 + n);
        return e;
    endfunction

    // First cycle at/after the minimum wait where acc_ready is high; done next.
    function automatic int model_done(int n);
        for (int c = S + 6 + n + MINW; c < 128; c++) begin
            if (acc_pat[c]) return c + 1;
        end
        return 126;
    endfunction

    function automatic snap_t sample();
        snap_t a;
        a.cmd_ready   = cmd_ready;
        a.busy        = busy;
        a.done        = done;
        a.err         = err;
        a.mem_rd_en   = mem_rd_en;
        a.mem_addr    = mem_addr;
        a.w_valid     = w_valid;
        a.wdata       = wdata;
        a.if_valid    = if_valid;
        a.if_data     = if_data;
        a.instr_valid = instr_valid;
        a.instr       = instr;
        a.start       = start;
        return a;
    endfunction

    task automatic check(input string name, input snap_t exp);
        snap_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one cycle; new read data is presented every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
        #1;
    endtask

    // Offer a command in the current (idle) cycle and check every cycle up to
    // the first idle cycle afterwards. rst_at>0 asserts reset during that cycle.
    task automatic run_cmd(input string tag, input logic [9:0] wb,
                           input logic [9:0] ab, input int n, input int d,
                           input int noise, input int rst_at);
        int last;
        last = (n == 0 || n > AMAX) ? 2 : d + 1;
        if (rst_at > 0) last = rst_at + 1;
        cmd_valid  = 1'b1;
        cmd_w_base = wb;
        cmd_a_base = ab;
        cmd_a_rows = 5'(n);
        acc_ready  = acc_pat[0];
        for (int k = 1; k <= last; k++) begin
            tick();
            if (rst_at > 0 && k == last)
                check($sformatf("%s_c%0d", tag, k), idle_snap());
            else
                check($sformatf("%s_c%0d", tag, k), model(k, wb, ab, n, d, mem_rdata));
            acc_ready = (k < 128) ? acc_pat[k] : 1'b1;
            rst       = (k == rst_at) && (k < last);
            if (noise != 0 && k < last) begin
                cmd_valid  = (noise == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                cmd_w_base = 10'($urandom);
                cmd_a_base = 10'($urandom);
                cmd_a_rows = 5'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
    endtask

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d;
        logic [9:0] wb;
        logic [9:0] ab;

        vecs[0] = '{10'h010, 10'h040,  3,  0, 16, 2};
        vecs[1] = '{10'h010, 10'h040,  0,  0,  0, 1};
        vecs[2] = '{10'h010, 10'h040, 17,  0,  0, 1};
        vecs[3] = '{10'h3FE, 10'h100,  1,  0, 14, 0};
        vecs[4] = '{10'h200, 10'h3FE,  4, 20, 21, 1};
        vecs[5] = '{10'h0AA, 10'h155, 16,  0, 29, 2};
        vecs[6] = '{10'h123, 10'h321, 31,  0,  0, 0};
        vecs[7] = '{10'h001, 10'h3FF,  2, 15, 16, 1};

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_w_base = '0;
        cmd_a_base = '0;
        cmd_a_rows = '0;
        acc_ready  = 1'b0;
        mem_rdata  = '0;

        tick();
        tick();
        check("reset_state", idle_snap());
        rst = 1'b0;
        tick();
        check("idle_after_reset", idle_snap());

        // Directed table
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 128; c++) acc_pat[c] = (c >= vecs[i].acc_from);
            run_cmd($sformatf("vec%0d", i), vecs[i].wb, vecs[i].ab, vecs[i].n,
                    vecs[i].exp_done, vecs[i].noise, 0);
        end

        // acc_ready pulse before the minimum wait is ignored
        for (int c = 0; c < 128; c++) acc_pat[c] = (c == 13) || (c >= 18);
        run_cmd("early_acc", 10'h010, 10'h040, 3, 19, 0, 0);

        // Reset in the middle of the activation load aborts the command
        for (int c = 0; c < 128; c++) acc_pat[c] = 1'b1;
        run_cmd("rst_mid", 10'h010, 10'h040, 3, 16, 1, 8);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("post_rst_%0d", i), idle_snap());
            acc_ready = 1'($urandom_range(0, 1));
        end

        // Randomized commands, issued back to back
        for (int r = 0; r < 30; r++) begin
            wb = 10'($urandom);
            ab = 10'($urandom);
            n  = $urandom_range(0, 19);
            for (int c = 0; c < 128; c++)
                acc_pat[c] = ($urandom_range(0, 2) == 0) || (c >= 60);
            d = model_done(n);
            run_cmd($sformatf("rnd%0d", r), wb, ab, n, d, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
